// File: rtl/dct_it_2d_ctrl.sv
// Row/column sequencer for an 8x8 inverse binDCT sharing one 1-D IDCT math pipeline.
// Pass 0 fills a transpose buffer from input rows; pass 1 runs its columns into a drained output buffer.
module dct_it_2d_ctrl #(
  parameter int MATH_LAT = 17,
  parameter int W_D      = 16,
  parameter int W_O      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [8*W_D-1:0] s_data,
  output logic [8*W_D-1:0] math_in_data,
  input  logic [8*W_D-1:0] math_out_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [8*W_O-1:0] m_data,
  output logic             m_last,
  output logic             busy
);

  typedef enum logic [1:0] {S_ROW, S_WAIT_T, S_COL} state_t;

  state_t           state, state_nxt;
  logic [2:0]       row_cnt, col_cnt, rd_ptr;
  logic [3:0]       wr_cnt;
  logic             tbuf_done;
  logic [MATH_LAT:0] tag_vld, tag_pass;
  logic [2:0]       tag_idx [MATH_LAT+1];
  logic [W_D-1:0]   tbuf [8][8];
  logic [8*W_O-1:0] obuf [8];

  logic             row_hs, issue, last_hs, obuf_free;
  logic             pop_vld, pop_pass, cap0, cap1, cap0_last;
  logic [2:0]       pop_idx;
  logic [8*W_D-1:0] col_data;

  // The tag at the end of the delay line lines up with the result on math_out_data.
  assign pop_vld   = tag_vld[MATH_LAT];
  assign pop_pass  = tag_pass[MATH_LAT];
  assign pop_idx   = tag_idx[MATH_LAT];
  assign cap0      = pop_vld && !pop_pass;
  assign cap1      = pop_vld && pop_pass;
  assign cap0_last = cap0 && (pop_idx == 3'd7);

  assign row_hs    = s_valid && s_ready;
  assign issue     = row_hs || (state == S_COL);

  assign m_valid   = ({1'b0, rd_ptr} < wr_cnt);
  assign m_data    = obuf[rd_ptr];
  assign m_last    = (rd_ptr == 3'd7);
  assign last_hs   = m_valid && m_ready && m_last;
  // A buffer that empties on this very edge is free for the next block's columns.
  assign obuf_free = (wr_cnt == 4'd0) || last_hs;

  assign busy = (|tag_vld) || (state != S_ROW) || (row_cnt != 3'd0) || (wr_cnt != 4'd0);

  always_comb begin
    col_data = '0;
    for (int k = 0; k < 8; k++) begin
      col_data[k*W_D +: W_D] = tbuf[k][col_cnt];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_ROW:    if (row_hs && (row_cnt == 3'd7)) state_nxt = S_WAIT_T;
      S_WAIT_T: if ((tbuf_done || cap0_last) && obuf_free) state_nxt = S_COL;
      S_COL:    if (col_cnt == 3'd7) state_nxt = S_ROW;
      default:  state_nxt = S_ROW;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_ROW;
      s_ready      <= 1'b0;
      row_cnt      <= '0;
      col_cnt      <= '0;
      rd_ptr       <= '0;
      wr_cnt       <= '0;
      tbuf_done    <= 1'b0;
      math_in_data <= '0;
      tag_vld      <= '0;
      tag_pass     <= '0;
      for (int i = 0; i <= MATH_LAT; i++) tag_idx[i] <= '0;
      for (int i = 0; i < 8; i++) obuf[i] <= '0;
    end else begin
      state     <= state_nxt;
      s_ready   <= (state_nxt == S_ROW);
      tbuf_done <= (state_nxt == S_WAIT_T) && (tbuf_done || cap0_last);

      if (row_hs) row_cnt <= row_cnt + 3'd1;
      if (state == S_COL) col_cnt <= col_cnt + 3'd1;

      if (row_hs) begin
        math_in_data <= s_data;
      end else if (state == S_COL) begin
        math_in_data <= col_data;
      end

      tag_vld    <= {tag_vld[MATH_LAT-1:0], issue};
      tag_pass   <= {tag_pass[MATH_LAT-1:0], (state == S_COL)};
      tag_idx[0] <= (state == S_COL) ? col_cnt : row_cnt;
      for (int i = 1; i <= MATH_LAT; i++) tag_idx[i] <= tag_idx[i-1];

      if (cap1) begin
        for (int j = 0; j < 8; j++) begin
          obuf[pop_idx][j*W_O +: W_O] <= math_out_data[j*W_D +: W_O];
        end
      end

      if (last_hs) begin
        wr_cnt <= '0;
        rd_ptr <= '0;
      end else begin
        if (cap1) wr_cnt <= wr_cnt + 4'd1;
        if (m_valid && m_ready) rd_ptr <= rd_ptr + 3'd1;
      end
    end
  end

  // Transpose storage carries no reset; its contents are only read after being written.
  always_ff @(posedge clk) begin
    if (cap0) begin
      for (int j = 0; j < 8; j++) begin
        tbuf[pop_idx][j] <= math_out_data[j*W_D +: W_D];
      end
    end
  end

endmodule

// File: tb/tb_dct_it_2d_ctrl.sv
// Bench for dct_it_2d_ctrl: a stand-in 1-D math pipeline plus a scoreboard of expected column beats.
module tb_dct_it_2d_ctrl;
  localparam int MATH_LAT = 17;
  localparam int W_D      = 16;
  localparam int W_O      = 16;

  typedef struct packed {
    logic [127:0] data;
    logic         last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [127:0] s_data = '0;
  logic [127:0] math_in_data, math_out_data, m_data;
  logic         m_valid, m_ready, m_last, busy;
  logic         m_ready_man = 1'b1;
  logic         rnd_ready = 1'b1;
  logic         rand_mode = 1'b0;

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           hs_count = 0;
  beat_t        exp_q[$];
  logic [127:0] blk [8];
  logic [127:0] colin [8];
  logic [127:0] pipe [MATH_LAT];
  logic         hold_prev = 1'b0;
  logic [127:0] hold_data = '0;

  assign m_ready = rand_mode ? rnd_ready : m_ready_man;
  assign math_out_data = pipe[MATH_LAT-1];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dct_it_2d_ctrl #(.MATH_LAT(MATH_LAT), .W_D(W_D), .W_O(W_O)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .math_in_data(math_in_data), .math_out_data(math_out_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy)
  );

  // Arbitrary lane-mixing transform standing in for the 1-D IDCT; the controller only routes data.
  function automatic logic [127:0] math_f(input logic [127:0] v);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[i*16 +: 16] = 16'(v[i*16 +: 16] * 16'(i + 3)) - v[((i + 1) % 8)*16 +: 16];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    pipe[0] <= math_f(math_in_data);
    for (int i = 1; i < MATH_LAT; i++) pipe[i] <= pipe[i-1];
  end

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 99) < 75);
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic checkInt(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Output monitor: scoreboard compare on each handshake, and hold-stability under back-pressure.
  always @(negedge clk) begin
    beat_t b;
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        checkBit("hold_valid", m_valid, 1'b1);
        checkOutput("hold_data", m_data, hold_data);
      end
      if (m_valid && m_ready) begin
        hs_count++;
        checkBit("beat_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          b = exp_q.pop_front();
          checkOutput("beat_data", m_data, b.data);
          checkBit("beat_last", m_last, b.last);
        end
      end
      hold_prev = m_valid && !m_ready;
      hold_data = m_data;
    end
  end

  task automatic computeExpected();
    logic [127:0] rr [8];
    logic [127:0] col;
    beat_t        b;
    for (int r = 0; r < 8; r++) rr[r] = math_f(blk[r]);
    for (int c = 0; c < 8; c++) begin
      col = '0;
      for (int k = 0; k < 8; k++) col[k*16 +: 16] = rr[k][c*16 +: 16];
      colin[c] = col;
      b.data = math_f(col);
      b.last = (c == 7);
      exp_q.push_back(b);
    end
  endtask

  task automatic randomBlock();
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) begin
        blk[r][k*16 +: 16] = 16'($urandom_range(0, 2048)) - 16'd1024;
      end
    end
  endtask

  task automatic applyStimulus(input int drop_pct, output int t_first, output int t_last);
    logic acc, accepted;
    t_first = 0;
    t_last  = 0;
    computeExpected();
    for (int r = 0; r < 8; r++) begin
      while (drop_pct > 0 && $urandom_range(0, 99) < drop_pct) begin
        s_valid = 1'b0;
        s_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        @(posedge clk); #1;
      end
      s_valid  = 1'b1;
      s_data   = blk[r];
      accepted = 1'b0;
      for (int w = 0; w < 2000 && !accepted; w++) begin
        @(negedge clk);
        acc = s_ready;
        @(posedge clk); #1;
        accepted = acc;
      end
      checkBit("row_accept", accepted, 1'b1);
      if (r == 0) t_first = cyc;
      if (r == 7) t_last = cyc;
    end
    s_valid = 1'b0;
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 5000 && !done; i++) begin
      @(posedge clk); #1;
      done = (exp_q.size() == 0) && !busy;
    end
    checkBit("drain_done", done, 1'b1);
    checkBit("drain_no_valid", m_valid, 1'b0);
  endtask

  task automatic checkResetOutputs(input string phase);
    checkBit({phase, "_s_ready"}, s_ready, 1'b0);
    checkBit({phase, "_m_valid"}, m_valid, 1'b0);
    checkBit({phase, "_m_last"}, m_last, 1'b0);
    checkBit({phase, "_busy"}, busy, 1'b0);
    checkOutput({phase, "_m_data"}, m_data, '0);
    checkOutput({phase, "_math_in"}, math_in_data, '0);
  endtask

  initial begin
    int   t0, t7, base;
    logic found;

    $display("[TB] reset");
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst_n = 1'b1;
    #1;
    checkBit("s_ready_before_edge", s_ready, 1'b0);
    @(posedge clk); #1;
    checkBit("s_ready_after_edge", s_ready, 1'b1);

    $display("[TB] all-zero block, latency and busy");
    for (int r = 0; r < 8; r++) blk[r] = '0;
    applyStimulus(0, t0, t7);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (m_valid) found = 1'b1;
    end
    checkBit("first_valid_seen", found, 1'b1);
    checkInt("first_valid_latency", cyc - t0, 44);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (m_valid && m_ready && m_last) found = 1'b1;
    end
    checkBit("m_last_seen", found, 1'b1);
    checkBit("busy_at_last", busy, 1'b1);
    @(posedge clk); #1;
    checkBit("busy_after_last", busy, 1'b0);

    $display("[TB] DC-only block");
    for (int r = 0; r < 8; r++) blk[r] = '0;
    blk[0][15:0] = 16'h0100;
    applyStimulus(0, t0, t7);
    drain();

    $display("[TB] 20 random blocks with input gaps and random m_ready");
    rand_mode = 1'b1;
    for (int b = 0; b < 20; b++) begin
      randomBlock();
      applyStimulus(30, t0, t7);
    end
    drain();
    rand_mode = 1'b0;

    $display("[TB] output stall after beat 3 with a second block queued");
    m_ready_man = 1'b1;
    base = hs_count;
    randomBlock();
    applyStimulus(0, t0, t7);
    randomBlock();
    applyStimulus(0, t0, t7);
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(posedge clk); #1;
      if (hs_count == base + 3) found = 1'b1;
    end
    checkBit("stall_point_reached", found, 1'b1);
    m_ready_man = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    checkBit("stall_s_ready", s_ready, 1'b0);
    checkBit("stall_m_valid", m_valid, 1'b1);
    checkBit("stall_busy", busy, 1'b1);
    checkOutput("stall_no_col_issue", math_in_data, blk[7]);
    m_ready_man = 1'b1;
    drain();

    $display("[TB] buffer empties on the last pass-0 capture edge");
    m_ready_man = 1'b0;
    randomBlock();
    applyStimulus(0, t0, t7);
    randomBlock();
    applyStimulus(0, t0, t7);
    while (cyc < t7 + 10) begin @(posedge clk); #1; end
    m_ready_man = 1'b1;
    while (cyc < t7 + 18) begin @(posedge clk); #1; end
    checkOutput("col_not_yet_issued", math_in_data, blk[7]);
    @(posedge clk); #1;
    checkOutput("col0_issue", math_in_data, colin[0]);
    drain();

    $display("[TB] reset during column issue 4");
    m_ready_man = 1'b1;
    randomBlock();
    applyStimulus(0, t0, t7);
    while (cyc < t7 + 23) begin @(posedge clk); #1; end
    checkOutput("col4_issue", math_in_data, colin[4]);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    randomBlock();
    applyStimulus(0, t0, t7);
    drain();
    repeat (60) @(posedge clk);
    #1;
    checkBit("no_stale_beats", m_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
